// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg: register map, bit positions, channel states and helpers for the DMA controller
package dma_ctrl_pkg;
  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_CMD    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int CMD_START  = 0;
  localparam int CMD_DIR    = 1;
  localparam int CMD_IRQ_EN = 2;
  localparam int ST_DONE    = 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BUSY} ch_state_e;
  // Merge new_v into old_v byte-by-byte under the AXI write strobes
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dma_ch_fsm.sv
// dma_ch_fsm: per-channel transfer tracker (start pulse, busy, sticky done, latched response)
module dma_ch_fsm
  import dma_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_clr,
  input  logic       i_idle,
  input  logic [1:0] i_resp,
  output logic       o_start,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_resp
);
  ch_state_e r_state, w_next;
  logic r_start, r_done;
  logic [1:0] r_resp;
  logic w_finish;
  assign w_finish = (r_state == S_BUSY) && i_idle;
  // Next state: ARMED holds until the engine drops idle, BUSY until it raises idle again
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_ARMED : S_IDLE;
      S_ARMED: w_next = i_idle ? S_ARMED : S_BUSY;
      S_BUSY:  w_next = i_idle ? S_IDLE : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  // State, one-cycle start pulse on ARMED entry, done/resp latch where a new done beats W1C
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= 2'b00;
    end else begin
      r_state <= w_next;
      r_start <= (r_state == S_IDLE) && i_start;
      r_done  <= w_finish ? 1'b1 : (i_clr ? 1'b0 : r_done);
      r_resp  <= w_finish ? i_resp : r_resp;
    end
  assign o_start = r_start;
  assign o_busy  = r_state != S_IDLE;
  assign o_done  = r_done;
  assign o_resp  = r_resp;
endmodule

// File: rtl/dma_multi_ch_ctrl.sv
// dma_multi_ch_ctrl: AXI4-Lite register file commanding NUM_CH independent DMA engines
module dma_multi_ch_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int AXIL_ADDR_W = 6
)(
  input  logic                     s_axi_lite_aclk,
  input  logic                     axi_resetnn,
  input  logic [AXIL_ADDR_W-1:0]   s_axi_lite_awaddr,
  input  logic                     s_axi_lite_awvalid,
  output logic                     s_axi_lite_awready,
  input  logic [31:0]              s_axi_lite_wdata,
  input  logic [3:0]               s_axi_lite_wstrb,
  input  logic                     s_axi_lite_wvalid,
  output logic                     s_axi_lite_wready,
  output logic [1:0]               s_axi_lite_bresp,
  output logic                     s_axi_lite_bvalid,
  input  logic                     s_axi_lite_bready,
  input  logic [AXIL_ADDR_W-1:0]   s_axi_lite_araddr,
  input  logic                     s_axi_lite_arvalid,
  output logic                     s_axi_lite_arready,
  output logic [31:0]              s_axi_lite_rdata,
  output logic [1:0]               s_axi_lite_rresp,
  output logic                     s_axi_lite_rvalid,
  input  logic                     s_axi_lite_rready,
  output logic [NUM_CH-1:0]        dma_start,
  output logic [NUM_CH-1:0]        dma_dir,
  output logic [NUM_CH*ADDR_W-1:0] dma_addr,
  output logic [NUM_CH*LEN_W-1:0]  dma_len,
  input  logic [NUM_CH-1:0]        dma_idle,
  input  logic [NUM_CH*2-1:0]      dma_resp,
  output logic                     irq
);
  localparam int CH_W = AXIL_ADDR_W - 4;
  logic r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [AXIL_ADDR_W-1:0] r_awaddr;
  logic [31:0] r_wdata, r_rdata, w_rdata;
  logic [3:0] r_wstrb;
  logic [1:0] r_bresp, r_rresp, w_rresp, w_wreg, w_rreg;
  logic [ADDR_W-1:0] r_addr [NUM_CH];
  logic [LEN_W-1:0] r_len [NUM_CH];
  logic [1:0] w_resp [NUM_CH];
  logic [NUM_CH-1:0] r_dir, r_irq_en, w_busy, w_done, w_start_req, w_clr, w_wsel, w_rsel;
  logic [CH_W-1:0] w_wch, w_rch;
  logic w_commit, w_werr, w_wok, w_unused;
  assign w_wreg   = r_awaddr[3:2];
  assign w_wch    = r_awaddr[AXIL_ADDR_W-1:4];
  assign w_rreg   = s_axi_lite_araddr[3:2];
  assign w_rch    = s_axi_lite_araddr[AXIL_ADDR_W-1:4];
  assign w_unused = ^{r_awaddr[1:0], s_axi_lite_araddr[1:0]};
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;
  assign w_werr   = !(|w_wsel) || (w_wreg != REG_STATUS && |(w_wsel & w_busy));
  assign w_wok    = w_commit && !w_werr;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wsel[i]      = w_wch == CH_W'(i);
    assign w_rsel[i]      = w_rch == CH_W'(i);
    assign w_start_req[i] = w_wok && w_wsel[i] && w_wreg == REG_CMD && r_wstrb[0] && r_wdata[CMD_START];
    assign w_clr[i]       = w_wok && w_wsel[i] && w_wreg == REG_STATUS && r_wstrb[0] && r_wdata[ST_DONE];
    assign dma_addr[i*ADDR_W +: ADDR_W] = r_addr[i];
    assign dma_len[i*LEN_W +: LEN_W]    = r_len[i];
    dma_ch_fsm u_fsm (
      .clk     (s_axi_lite_aclk),
      .rst_n   (axi_resetnn),
      .i_start (w_start_req[i]),
      .i_clr   (w_clr[i]),
      .i_idle  (dma_idle[i]),
      .i_resp  (dma_resp[i*2 +: 2]),
      .o_start (dma_start[i]),
      .o_busy  (w_busy[i]),
      .o_done  (w_done[i]),
      .o_resp  (w_resp[i])
    );
  end
  // Write channel: AW and W captured independently, committed together, one B per commit
  always_ff @(posedge s_axi_lite_aclk or negedge axi_resetnn)
    if (!axi_resetnn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (s_axi_lite_awvalid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_lite_awaddr;
      end
      if (s_axi_lite_wvalid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_lite_wdata;
        r_wstrb  <= s_axi_lite_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_werr ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_lite_bready) r_bvalid <= 1'b0;
    end
  // Register storage: ADDR/LEN honour byte strobes, CMD fields need strobe lane 0
  always_ff @(posedge s_axi_lite_aclk or negedge axi_resetnn)
    if (!axi_resetnn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_addr[c] <= '0;
        r_len[c]  <= '0;
      end
      r_dir    <= '0;
      r_irq_en <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_wok && w_wsel[c]) begin
          if (w_wreg == REG_ADDR) r_addr[c] <= ADDR_W'(apply_strb(32'(r_addr[c]), r_wdata, r_wstrb));
          if (w_wreg == REG_LEN) r_len[c] <= LEN_W'(apply_strb(32'(r_len[c]), r_wdata, r_wstrb));
          if (w_wreg == REG_CMD && r_wstrb[0]) begin
            r_dir[c]    <= r_wdata[CMD_DIR];
            r_irq_en[c] <= r_wdata[CMD_IRQ_EN];
          end
        end
    end
  // Read mux over the addressed channel; unknown channels read zero with SLVERR
  always_comb begin
    w_rdata = '0;
    w_rresp = |w_rsel ? RESP_OKAY : RESP_SLVERR;
    for (int c = 0; c < NUM_CH; c++)
      if (w_rsel[c])
        w_rdata = w_rreg == REG_ADDR ? 32'(r_addr[c]) :
                  w_rreg == REG_LEN  ? 32'(r_len[c]) :
                  w_rreg == REG_CMD  ? {29'b0, r_irq_en[c], r_dir[c], 1'b0} :
                  {27'b0, dma_idle[c], w_resp[c], w_done[c], w_busy[c]};
  end
  // Read channel: data registered on AR handshake and held until the master takes it
  always_ff @(posedge s_axi_lite_aclk or negedge axi_resetnn)
    if (!axi_resetnn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (s_axi_lite_arvalid && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rresp;
    end else if (s_axi_lite_rready) r_rvalid <= 1'b0;
  assign s_axi_lite_awready = !r_aw_held;
  assign s_axi_lite_wready  = !r_w_held;
  assign s_axi_lite_bvalid  = r_bvalid;
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_arready = !r_rvalid;
  assign s_axi_lite_rvalid  = r_rvalid;
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;
  assign dma_dir = r_dir;
  assign irq     = |(w_done & r_irq_en);
endmodule
